cpu_run_ctrl: RTL
=================

Name: cpu_run_ctrl

Overview:
- Synthesizable run controller for the RISC-V core in bench and FPGA bring-up.
- Sequences core reset and gates core clock-enable.
- Counts cycles and retired instructions; detects end-of-program from the retire stream (EBREAK, self-loop, timeout).
- Parametrised replacement for fixed-delay reset/run/finish sequencing: one instance per core, between the top level and the cpu instance.

Parameters:
- RESET_CYCLES, 4, cycles core_reset is held high after start; legal 1..255.
- MAX_CYCLES, 25, timeout in RUN cycles; 0 disables the timeout.
- CNT_W, 32, width of the cycle and instret counters.
- TRACE_DEPTH, 8, PC trace entries, power of two; used only with CPU_RUN_TRACE_EN.

Ports:
- clk  in  1  system clock; all state is on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  one-cycle pulse; begins a run from IDLE or HALTED.
- abort  in  1  level; forces the return to IDLE.
- retire_valid  in  1  the core retired an instruction this cycle.
- retire_pc  in  32  PC of the retired instruction.
- retire_instr  in  32  encoding of the retired instruction.
- core_reset  out  1  reset to the cpu; active-high.
- core_clk_en  out  1  clock-enable to the cpu.
- running  out  1  high in RUN.
- done  out  1  high in HALTED.
- status  out  2  0 none, 1 EBREAK, 2 self-loop, 3 timeout.
- cycle_count  out  CNT_W  RUN cycles elapsed.
- instret_count  out  CNT_W  instructions retired in RUN.
- last_pc  out  32  PC of the most recent retire.

Behaviour:
- Reset values: state IDLE, core_reset=1, core_clk_en=0, running=0, done=0, status=0, cycle_count=0, instret_count=0, last_pc=0.
- All outputs are registered; no combinational path from any input to any output.
- States: IDLE, RST_HOLD, RUN, HALTED.
- IDLE: core_reset=1, core_clk_en=0.
  - start -> RST_HOLD.
  - On that edge: clear hold counter, cycle_count, instret_count, status and last_pc.
- RST_HOLD: core_reset=1, core_clk_en=0.
  - Hold counter increments each cycle.
  - After exactly RESET_CYCLES cycles in RST_HOLD -> RUN.
  - First cycle with core_reset=0 is the cycle after the transition.
- RUN: core_reset=0, core_clk_en=1, running=1.
  - cycle_count increments every cycle and saturates at all-ones.
  - On retire_valid: instret_count increments (saturating) and last_pc <= retire_pc.
- Halt checks are made in RUN only, evaluated on the same edge. Priority when several hold together:
  - retire_valid and retire_instr==32'h00100073 -> status 1.
  - retire_valid and retire_instr==32'h0000006F (jal x0,0) -> status 2.
  - MAX_CYCLES!=0 and cycle_count==MAX_CYCLES-1 -> status 3.
- On a halt -> HALTED.
  - The halting retire is counted in instret_count and captured in last_pc.
  - The cycle of the halting edge is counted, so a timeout reports cycle_count==MAX_CYCLES.
- HALTED: core_clk_en=0, core_reset=0, so core state is frozen for inspection.
  - done=1; counters and status hold.
  - start -> RST_HOLD, with the same clears as from IDLE.
- start while in RST_HOLD or RUN: ignored.
- abort (any state except IDLE) -> IDLE next edge.
  - core_reset=1, status=0; counters hold their values.
  - abort has priority over start and over halt detection in the same cycle.
- Asynchronous reset mid-run: immediate return to reset values; core_reset asserts without waiting for a clock edge.
- retire_valid outside RUN: ignored.

Optional Feature:
- Macro: CPU_RUN_TRACE_EN.
- Defined:
  - Adds a circular buffer of the last TRACE_DEPTH retired PCs, written on every retire_valid in RUN.
  - Write pointer wraps modulo TRACE_DEPTH and clears on each start.
  - Extra ports: trace_idx in log2(TRACE_DEPTH) (0 = newest); trace_pc out 32, registered, 1-cycle read latency.
  - Entries never written since the last start read 0.
- Undefined: no buffer and no extra ports; all other behaviour identical.

Test Plan:
- Reset then start, no retires, MAX_CYCLES=25, RESET_CYCLES=4 -> core_reset high 4 cycles after start; RUN for 25 cycles; done=1; status=3; cycle_count=25; instret_count=0; core_clk_en=0.
- Start, retire 5 instrs at PCs 0,4,8,C,10, the last being 00100073 -> status=1, instret_count=5, last_pc=0x10; done on the edge after the EBREAK retire.
- Retire 0000006F at PC 0x20 on cycle 24 of RUN (timeout cycle) -> status=2, not 3 (priority check).
- Abort on RUN cycle 7 -> IDLE, core_reset=1, status=0, cycle_count=7; a second start clears all counters and repeats the RST_HOLD timing.
- Assert reset asynchronously mid-RUN, between clock edges -> core_reset=1 and running=0 before the next edge; all outputs at reset values.
- With CPU_RUN_TRACE_EN, TRACE_DEPTH=8, retire 10 PCs 0x00..0x24 -> trace_idx 0 gives 0x24, idx 7 gives 0x08; the oldest two are overwritten.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - reset sequencing, clock gating and end-of-program detection for one RISC-V core
// Optional PC trace buffer enabled by defining CPU_RUN_TRACE_EN.
module cpu_run_ctrl #(
    parameter int RESET_CYCLES = 4,
    parameter int MAX_CYCLES   = 25,
    parameter int CNT_W        = 32,
    parameter int TRACE_DEPTH  = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           abort,
    input  logic                           retire_valid,
    input  logic [31:0]                    retire_pc,
    input  logic [31:0]                    retire_instr,
`ifdef CPU_RUN_TRACE_EN
    input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx,
    output logic [31:0]                    trace_pc,
`endif
    output logic                           core_reset,
    output logic                           core_clk_en,
    output logic                           running,
    output logic                           done,
    output logic [1:0]                     status,
    output logic [CNT_W-1:0]               cycle_count,
    output logic [CNT_W-1:0]               instret_count,
    output logic [31:0]                    last_pc
);

    localparam logic [31:0]      INSTR_EBREAK = 32'h0010_0073;
    localparam logic [31:0]      INSTR_SELF   = 32'h0000_006F;
    localparam logic [7:0]       HOLD_LAST    = 8'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_AT   = CNT_W'(MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT      = '1;

    typedef enum logic [1:0] {IDLE, RST_HOLD, RUN, HALTED} state_t;

    state_t     state;
    logic [7:0] hold_cnt;

    logic do_abort, do_start, do_retire;
    logic hit_ebreak, hit_self, hit_timeout;

    // abort outranks every other event, so derive the qualified events once
    assign do_abort    = abort && (state != IDLE);
    assign do_start    = start && !do_abort && ((state == IDLE) || (state == HALTED));
    assign do_retire   = retire_valid && !do_abort && (state == RUN);
    assign hit_ebreak  = retire_valid && (retire_instr == INSTR_EBREAK);
    assign hit_self    = retire_valid && (retire_instr == INSTR_SELF);
    assign hit_timeout = (MAX_CYCLES != 0) && (cycle_count == TIMEOUT_AT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            hold_cnt      <= '0;
            core_reset    <= 1'b1;
            core_clk_en   <= 1'b0;
            running       <= 1'b0;
            done          <= 1'b0;
            status        <= 2'd0;
            cycle_count   <= '0;
            instret_count <= '0;
            last_pc       <= '0;
        end else if (do_abort) begin
            state       <= IDLE;
            core_reset  <= 1'b1;
            core_clk_en <= 1'b0;
            running     <= 1'b0;
            done        <= 1'b0;
            status      <= 2'd0;
        end else begin
            case (state)
                IDLE, HALTED: begin
                    if (do_start) begin
                        state         <= RST_HOLD;
                        hold_cnt      <= '0;
                        core_reset    <= 1'b1;
                        core_clk_en   <= 1'b0;
                        done          <= 1'b0;
                        status        <= 2'd0;
                        cycle_count   <= '0;
                        instret_count <= '0;
                        last_pc       <= '0;
                    end
                end
                RST_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state       <= RUN;
                        core_reset  <= 1'b0;
                        core_clk_en <= 1'b1;
                        running     <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                RUN: begin
                    if (cycle_count != CNT_SAT)
                        cycle_count <= cycle_count + 1'b1;
                    if (retire_valid) begin
                        last_pc <= retire_pc;
                        if (instret_count != CNT_SAT)
                            instret_count <= instret_count + 1'b1;
                    end
                    if (hit_ebreak || hit_self || hit_timeout) begin
                        state       <= HALTED;
                        core_clk_en <= 1'b0;
                        running     <= 1'b0;
                        done        <= 1'b1;
                        status      <= hit_ebreak ? 2'd1 : (hit_self ? 2'd2 : 2'd3);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CPU_RUN_TRACE_EN
    localparam int PW = $clog2(TRACE_DEPTH);

    logic [31:0]            trace_mem [TRACE_DEPTH];
    logic [TRACE_DEPTH-1:0] trace_vld;
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;

    // wr_ptr points at the next free slot, so the newest entry sits one behind it
    assign rd_ptr = wr_ptr - PW'(1) - trace_idx;

    always_ff @(posedge clk) begin
        if (do_retire)
            trace_mem[wr_ptr] <= retire_pc;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            trace_vld <= '0;
            trace_pc  <= '0;
        end else begin
            trace_pc <= trace_vld[rd_ptr] ? trace_mem[rd_ptr] : 32'd0;
            if (do_start) begin
                wr_ptr    <= '0;
                trace_vld <= '0;
            end else if (do_retire) begin
                wr_ptr            <= wr_ptr + PW'(1);
                trace_vld[wr_ptr] <= 1'b1;
            end
        end
    end
`endif

endmodule
